// File: rtl/blk_e5a779.sv
// rtl/blk_e5a779.sv - IJTAG data mux takeover controller (quiesce handshake, timeout, guarded release)
module blk_e5a779 #(
  parameter int WIDTH       = 3,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255,
  parameter int GUARD       = 2
) (
  input  logic             ijtag_tck,
  input  logic             ijtag_reset,
  input  logic             ijtag_sel,
  input  logic             ijtag_ue,
  input  logic             tdr_takeover,
  input  logic [WIDTH-1:0] tdr_data,
  input  logic             func_idle,
  output logic             func_hold_req,
  output logic             ijtag_select,
  output logic [WIDTH-1:0] ijtag_data_out,
  output logic             status_active,
  output logic             status_timeout
);

  // One counter serves both the REQ wait and the RELEASE guard, so it must fit the larger of the two.
  localparam int TO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int GD_W   = (GUARD > 1) ? $clog2(GUARD) : 1;
  localparam int CNT_W  = (TO_W > GD_W) ? TO_W : GD_W;
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SWITCH  = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   hold_q, hold_d;
  logic                   select_q, select_d;
  logic                   active_q, active_d;
  logic                   timeout_q, timeout_d;
  logic [WIDTH-1:0]       data_q, data_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   idle_s;

  assign idle_s         = sync_q[SYNC_STAGES-1];
  assign func_hold_req  = hold_q;
  assign ijtag_select   = select_q;
  assign status_active  = active_q;
  assign status_timeout = timeout_q;
  assign ijtag_data_out = data_q;

  // Shift chain bringing the asynchronous idle acknowledge into the tck domain.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], func_idle};
  end

  // Data register loads on update whenever the TDR is selected, regardless of mux state.
  always_comb begin
    data_d = data_q;
    if (ijtag_sel && ijtag_ue) begin
      data_d = tdr_data;
    end
  end

  // Takeover sequencing; hold/select are registered alongside the state so the
  // select-implies-hold ordering is explicit at every transition.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    select_d  = select_q;
    active_d  = active_q;
    timeout_d = timeout_q;
    case (state_q)
      S_IDLE: begin
        if (tdr_takeover && !timeout_q) begin
          state_d = S_REQ;
          hold_d  = 1'b1;
          cnt_d   = '0;
        end else if (!tdr_takeover) begin
          timeout_d = 1'b0;
        end
      end
      S_REQ: begin
        if (!tdr_takeover) begin
          state_d = S_RELEASE;
          cnt_d   = '0;
        end else if (idle_s) begin
          state_d  = S_SWITCH;
          select_d = 1'b1;
          active_d = 1'b1;
        end else if (cnt_q == TO_LAST) begin
          state_d   = S_IDLE;
          hold_d    = 1'b0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_SWITCH: begin
        if (!tdr_takeover) begin
          state_d  = S_RELEASE;
          select_d = 1'b0;
          active_d = 1'b0;
          cnt_d    = '0;
        end
      end
      S_RELEASE: begin
        if (cnt_q == GUARD_LAST) begin
          state_d = S_IDLE;
          hold_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d   = S_IDLE;
        cnt_d     = '0;
        hold_d    = 1'b0;
        select_d  = 1'b0;
        active_d  = 1'b0;
        timeout_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops select and hold together.
  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hold_q    <= 1'b0;
      select_q  <= 1'b0;
      active_q  <= 1'b0;
      timeout_q <= 1'b0;
      data_q    <= '0;
      sync_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      select_q  <= select_d;
      active_q  <= active_d;
      timeout_q <= timeout_d;
      data_q    <= data_d;
      sync_q    <= sync_d;
    end
  end

endmodule

// File: doc/blk_e5a779.md
Name: firebird7_in_gate1_tessent_data_mux_takeover_ctrl

Overview:
- Sequences the ijtag_select / ijtag_data_in side of a W-bit IJTAG-vs-functional data mux.
- A TDR takeover bit requests the path. The controller asks the functional domain to quiesce and waits for its idle acknowledge, with a timeout. Only then does it switch the mux to IJTAG data.
- On release, it deselects the mux before dropping the hold request, so the functional side never sees a half-switched path.
- Sits in the IJTAG network next to the data mux and is clocked by ijtag_tck.

Parameters:
- WIDTH, 3, width of the muxed data path.
- SYNC_STAGES, 2, flops synchronizing func_idle into ijtag_tck; legal values 2–4.
- TIMEOUT, 255, max cycles spent in REQ waiting for idle; legal 2–65535; counter width clog2(TIMEOUT).
- GUARD, 2, cycles in RELEASE with select low and hold still high; legal ≥1.

Ports:
- ijtag_tck  in  1  sole clock, rising edge.
- ijtag_reset  in  1  asynchronous, active-low reset.
- ijtag_sel  in  1  TDR selected in scan path.
- ijtag_ue  in  1  update-enable strobe.
- tdr_takeover  in  1  level request from TDR: 1 = take the path, 0 = release it.
- tdr_data  in  WIDTH  TDR data to drive into the mux.
- func_idle  in  1  functional-domain quiesced acknowledge; asynchronous to ijtag_tck.
- func_hold_req  out  1  request for the functional domain to quiesce and hold.
- ijtag_select  out  1  mux select: 1 = IJTAG data.
- ijtag_data_out  out  WIDTH  data to the mux ijtag_data_in.
- status_active  out  1  mux is currently selected (state SWITCH).
- status_timeout  out  1  sticky flag: quiesce handshake timed out.

Behaviour:
- Reset (async assert, sync release): state=IDLE, all outputs 0, count=0, synchronizer flops 0.
- All outputs are registered; no combinational input-to-output paths.
- Data register:
  - ijtag_data_out <= tdr_data on any edge with ijtag_sel & ijtag_ue, in any state; otherwise it holds.
  - Load is independent of the FSM.
- func_idle is passed through SYNC_STAGES flops to give idle_s.
- IDLE:
  - hold=0, select=0.
  - If tdr_takeover=1 and status_timeout=0: go to REQ, func_hold_req=1 from the same edge, count=0.
  - If tdr_takeover=0: clear status_timeout.
- REQ:
  - hold=1, select=0.
  - If tdr_takeover=0: go to RELEASE (abort).
  - Else if idle_s=1: go to SWITCH, ijtag_select=1 and status_active=1 on that edge.
  - Else if count==TIMEOUT-1: go to IDLE, hold=0, status_timeout=1.
  - Else count++.
  - Priority on simultaneous events: takeover-drop > idle > timeout.
- SWITCH:
  - hold=1, select=1.
  - Stays while tdr_takeover=1.
  - A drop of idle_s while in SWITCH is ignored.
  - If tdr_takeover=0: go to RELEASE; select and status_active drop on that edge.
- RELEASE:
  - select=0, hold=1, for exactly GUARD cycles (counter reused).
  - Then go to IDLE with hold=0.
  - Re-assertion of tdr_takeover during RELEASE is not honoured until IDLE is reached (next REQ earliest one edge after IDLE entry).
- Invariants:
  - ijtag_select=1 implies func_hold_req=1.
  - select never rises in the same cycle hold rises.
  - hold never falls in the same cycle select falls.
- Latency:
  - func_idle rising (with setup met) → ijtag_select high after SYNC_STAGES+1 edges.
  - takeover sampled high → hold high after 1 edge.
- Reset mid-operation: immediate async return to the reset values; select and hold drop together (accepted only under reset).

Test Plan:
- Reset: hold ijtag_reset=0 with random inputs → all outputs 0. Assert reset while in SWITCH → select, hold and status_active go to 0 asynchronously, with no clock edge.
- Normal takeover with defaults:
  - Sequence: load tdr_data=3'b101 via ijtag_sel&ue, set takeover=1, raise func_idle 4 cycles later.
  - Required: hold=1 after 1 edge; select=1 and status_active=1 exactly 3 edges after func_idle rises; ijtag_data_out=3'b101.
- Release ordering: from SWITCH, drop takeover → select=0 on next edge, hold stays 1 for 2 more cycles (GUARD=2), then hold=0; the invariants hold on every cycle.
- Timeout with TIMEOUT=255, func_idle held 0:
  - Required: hold=1 for 255 cycles, then status_timeout=1 and hold=0.
  - Keeping takeover=1 → no re-request.
  - takeover 0→1 → status_timeout clears, then a new REQ starts.
- Simultaneous events in REQ: idle_s rises on the cycle count==TIMEOUT-1 → SWITCH, status_timeout stays 0. Takeover drops on the same cycle idle_s rises → RELEASE, select never goes to 1.
- Data update while selected: in SWITCH, update tdr_data=3'b010 → ijtag_data_out=3'b010 one edge after ue, with select still 1. ijtag_ue pulse with ijtag_sel=0 → no change.
